// File: rtl/usbh_nes_joypad_port.sv
// NES controller port emulation: 4021-style strobe/shift register fed by a
// USB-decoded button snapshot, with a link-loss watchdog that releases all buttons.
module usbh_nes_joypad_port #(
  parameter int c_clk_hz     = 6000000,
  parameter int c_timeout_ms = 100
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_btn,
  input  logic       i_btn_valid,
  input  logic       i_strobe,
  input  logic       i_read,
  output logic       o_data,
  output logic [7:0] o_btn,
  output logic       o_stale
);

  localparam int c_timeout_cycles = c_clk_hz / 1000 * c_timeout_ms;
  localparam int c_count_w        = $clog2(c_timeout_cycles + 1);
  localparam logic [c_count_w-1:0] c_count_max  = c_count_w'(c_timeout_cycles);
  localparam logic [c_count_w-1:0] c_count_last = c_count_w'(c_timeout_cycles - 1);

  logic [7:0]           btn_reg;
  logic [7:0]           shift_reg;
  logic [c_count_w-1:0] count_reg;
  logic                 stale_reg;

  // Snapshot and watchdog: a fresh report always wins over the expiry clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_reg   <= 8'h00;
      count_reg <= '0;
      stale_reg <= 1'b1;
    end else if (i_btn_valid) begin
      btn_reg   <= i_btn;
      count_reg <= '0;
      stale_reg <= 1'b0;
    end else begin
      if (count_reg != c_count_max) begin
        count_reg <= count_reg + 1'b1;
      end
      if (count_reg == c_count_last) begin
        btn_reg   <= 8'h00;
        stale_reg <= 1'b1;
      end
    end
  end

  // Shift register only looks at the snapshot while strobed, so snapshot
  // updates during a read sequence never disturb the bits being shifted out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_reg <= 8'h00;
    end else if (i_strobe) begin
      shift_reg <= btn_reg;
    end else if (i_read) begin
      shift_reg <= {1'b1, shift_reg[7:1]};
    end
  end

  // While strobed the real 4021 passes the A button straight through.
  assign o_data  = i_strobe ? btn_reg[0] : shift_reg[0];
  assign o_btn   = btn_reg;
  assign o_stale = stale_reg;

endmodule

// File: tb/tb_usbh_nes_joypad_port.sv
// Directed bench: port behaviour on a long-timeout instance, watchdog timing
// on a second instance configured for a 10-cycle timeout.
module tb_usbh_nes_joypad_port;

  logic       clk = 1'b0;
  logic       rst, btn_valid, strobe, read;
  logic [7:0] btn;
  logic       data, stale;
  logic [7:0] btn_out;

  logic       w_rst, w_btn_valid;
  logic [7:0] w_btn;
  logic       w_data, w_stale;
  logic [7:0] w_btn_out;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  usbh_nes_joypad_port dut (
    .i_clk(clk), .i_rst(rst), .i_btn(btn), .i_btn_valid(btn_valid),
    .i_strobe(strobe), .i_read(read), .o_data(data), .o_btn(btn_out), .o_stale(stale)
  );

  usbh_nes_joypad_port #(.c_clk_hz(1000), .c_timeout_ms(10)) wdt (
    .i_clk(clk), .i_rst(w_rst), .i_btn(w_btn), .i_btn_valid(w_btn_valid),
    .i_strobe(1'b0), .i_read(1'b0), .o_data(w_data), .o_btn(w_btn_out), .o_stale(w_stale)
  );

  // Drive one read pulse; the CPU samples o_data in the pulse cycle before the edge.
  task automatic read_bit(output logic b);
    @(negedge clk);
    read = 1'b1;
    #1 b = data;
  endtask

  task automatic idle();
    @(negedge clk);
    read = 1'b0;
    btn_valid = 1'b0;
  endtask

  task automatic send_btn(input logic [7:0] v);
    @(negedge clk);
    read = 1'b0;
    btn = v;
    btn_valid = 1'b1;
    @(negedge clk);
    btn_valid = 1'b0;
  endtask

  task automatic latch();
    @(negedge clk);
    strobe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic read_seq(input string name, input int n, input logic [15:0] exp);
    logic b;
    for (int i = 0; i < n; i++) begin
      read_bit(b);
      compared++;
      if (b !== exp[i]) begin
        mismatched++;
        $display("FAIL %s read%0d: got %b expected %b", name, i + 1, b, exp[i]);
      end else
        $display("ok   %s read%0d = %b", name, i + 1, b);
    end
    idle();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; w_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; w_rst = 1'b0;
    #1;
    compared++;
    if (btn_out !== 8'h00 || stale !== 1'b1 || data !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_state: got btn=%h stale=%b data=%b expected 00/1/0", btn_out, stale, data);
    end else $display("ok   reset_state");
    compared++;
    if (w_btn_out !== 8'h00 || w_stale !== 1'b1) begin
      mismatched++;
      $display("FAIL wdt_reset_state: got btn=%h stale=%b expected 00/1", w_btn_out, w_stale);
    end else $display("ok   wdt_reset_state");
    latch();
    read_seq("reset_reads", 9, 16'b1_0000_0000);
  endtask

  task automatic test_basic_81();
    send_btn(8'h81);
    latch();
    read_seq("btn81", 10, 16'b11_1000_0001);
    compared++;
    if (stale !== 1'b0 || btn_out !== 8'h81) begin
      mismatched++;
      $display("FAIL btn81_status: got btn=%h stale=%b expected 81/0", btn_out, stale);
    end else $display("ok   btn81_status");
  endtask

  task automatic test_strobe_high_reads();
    logic b;
    send_btn(8'h02);
    @(negedge clk);
    strobe = 1'b1;
    for (int i = 0; i < 3; i++) begin
      read_bit(b);
      compared++;
      if (b !== 1'b0) begin
        mismatched++;
        $display("FAIL strobe_live_a%0d: got %b expected 0", i, b);
      end else $display("ok   strobe_live_a%0d = %b", i, b);
    end
    @(negedge clk);
    read = 1'b0;
    strobe = 1'b0;
    read_seq("after_strobe02", 2, 16'b10);
  endtask

  task automatic test_midseq_update();
    logic b;
    send_btn(8'hFF);
    latch();
    read_seq("ff_first", 2, 16'b11);
    send_btn(8'h00);
    compared++;
    if (btn_out !== 8'h00) begin
      mismatched++;
      $display("FAIL midseq_obtn: got %h expected 00", btn_out);
    end else $display("ok   midseq_obtn");
    read_seq("ff_rest", 7, 16'h7F);
    @(negedge clk);
    strobe = 1'b1;
    #1 b = data;
    compared++;
    if (b !== 1'b0) begin
      mismatched++;
      $display("FAIL strobe_live_after_update: got %b expected 0", b);
    end else $display("ok   strobe_live_after_update");
    @(negedge clk);
    strobe = 1'b0;
  endtask

  task automatic test_reset_midseq();
    send_btn(8'hFF);
    latch();
    read_seq("pre_reset", 1, 16'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if (data !== 1'b0 || stale !== 1'b1 || btn_out !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_midseq: got data=%b stale=%b btn=%h expected 0/1/00", data, stale, btn_out);
    end else $display("ok   reset_midseq");
    read_seq("post_reset", 3, 16'b000);
  endtask

  task automatic test_watchdog_expiry();
    @(negedge clk);
    w_btn = 8'h10;
    w_btn_valid = 1'b1;
    @(negedge clk);
    w_btn_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      compared++;
      if (i < 10) begin
        if (w_btn_out !== 8'h10 || w_stale !== 1'b0) begin
          mismatched++;
          $display("FAIL wdt_hold c%0d: got btn=%h stale=%b expected 10/0", i, w_btn_out, w_stale);
        end else $display("ok   wdt_hold c%0d", i);
      end else begin
        if (w_btn_out !== 8'h00 || w_stale !== 1'b1) begin
          mismatched++;
          $display("FAIL wdt_expire c%0d: got btn=%h stale=%b expected 00/1", i, w_btn_out, w_stale);
        end else $display("ok   wdt_expire c%0d", i);
      end
    end
  endtask

  task automatic test_back_to_back_valid_at_expiry();
    @(negedge clk);
    w_btn = 8'h10;
    w_btn_valid = 1'b1;
    @(negedge clk);
    w_btn_valid = 1'b0;
    for (int i = 1; i <= 9; i++) @(negedge clk);
    w_btn = 8'h20;
    w_btn_valid = 1'b1;
    @(negedge clk);
    w_btn_valid = 1'b0;
    compared++;
    if (w_btn_out !== 8'h20 || w_stale !== 1'b0) begin
      mismatched++;
      $display("FAIL wdt_valid_wins: got btn=%h stale=%b expected 20/0", w_btn_out, w_stale);
    end else $display("ok   wdt_valid_wins");
    for (int i = 1; i <= 9; i++) @(negedge clk);
    compared++;
    if (w_btn_out !== 8'h20 || w_stale !== 1'b0) begin
      mismatched++;
      $display("FAIL wdt_restart_hold: got btn=%h stale=%b expected 20/0", w_btn_out, w_stale);
    end else $display("ok   wdt_restart_hold");
    @(negedge clk);
    compared++;
    if (w_btn_out !== 8'h00 || w_stale !== 1'b1) begin
      mismatched++;
      $display("FAIL wdt_restart_expire: got btn=%h stale=%b expected 00/1", w_btn_out, w_stale);
    end else $display("ok   wdt_restart_expire");
  endtask

  initial begin
    rst = 1'b1; btn = 8'h00; btn_valid = 1'b0; strobe = 1'b0; read = 1'b0;
    w_rst = 1'b1; w_btn = 8'h00; w_btn_valid = 1'b0;
    test_reset();
    test_basic_81();
    test_strobe_high_reads();
    test_midseq_update();
    test_reset_midseq();
    test_watchdog_expiry();
    test_back_to_back_valid_at_expiry();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
